// File: rtl/fastclk_pkg.sv
// fastclk_pkg: shared types and helpers for the external fast-clock monitor.
//   state_t   : qualification FSM states.
//   mode_t    : encoding of the 2-bit fast_clk_sel mode input.
//   COUNT_W   : width of the window and edge counters and of last_count.
//   sat_inc() : saturating increment used by the edge counter.
package fastclk_pkg;

  localparam int unsigned COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    USE_DIV = 2'b00,
    QUALIFY = 2'b01,
    USE_EXT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_AUTO  = 2'b00,
    MODE_DIV   = 2'b01,
    MODE_EXT   = 2'b10,
    MODE_AUTO2 = 2'b11
  } mode_t;

  // Increment by one when inc is set, holding at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                 input logic               inc);
    if (inc && (v != COUNT_MAX)) begin
      return v + 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/extclk_edgedet.sv
// extclk_edgedet: brings an asynchronous clock-like input into the clk domain
// through a 2-FF synchroniser and produces a one-cycle pulse per rising edge.
//   clk  : sampling clock.
//   rst  : synchronous, active-high reset; clears all three flops.
//   d    : asynchronous input, treated purely as data.
//   rise : high for one clk cycle when the synchronised value goes 0 -> 1.
module extclk_edgedet (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Taken straight from flops, so the pulse is clean for the counter that
  // consumes it on the following edge (third clk edge after the pin sample).
  assign rise = sync2 & ~prev;

endmodule

// File: rtl/extclk_monitor.sv
// extclk_monitor: qualifies an external reference clock by counting its rising
// edges over fixed windows of the system clock, and drives the registered
// select for the fast-clock multiplexer.
//   clk          : system clock.
//   rst          : synchronous, active-high reset.
//   fast_clk_ext : external reference, asynchronous to clk (sampled as data).
//   mode         : 00/11 auto, 01 force divided, 10 force external.
//   fast_clk_sel : registered mux select, 1 = external, 0 = divided.
//   ext_ok       : last completed window had an in-range edge count.
//   last_count   : edge count of the last completed window.
//   window_done  : one-cycle pulse coincident with last_count/ext_ok updates.
module extclk_monitor
  import fastclk_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 50000,
  parameter int unsigned MIN_EDGES     = 6400,
  parameter int unsigned MAX_EDGES     = 6700,
  parameter int unsigned GOOD_WINDOWS  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fast_clk_ext,
  input  logic [1:0]         mode,
  output logic               fast_clk_sel,
  output logic               ext_ok,
  output logic [COUNT_W-1:0] last_count,
  output logic               window_done
);

  localparam logic [COUNT_W-1:0] WIN_LAST  = COUNT_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] MIN_COUNT = COUNT_W'(MIN_EDGES);
  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_EDGES);
  localparam int unsigned        GCNT_W    = (GOOD_WINDOWS < 2) ? 1 : $clog2(GOOD_WINDOWS + 1);
  localparam logic [GCNT_W-1:0]  GOOD_TGT  = GCNT_W'(GOOD_WINDOWS);

  logic               rise;
  logic [COUNT_W-1:0] win_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic [COUNT_W-1:0] eval_cnt;
  logic               eval;
  logic               win_good;

  state_t             state;
  state_t             state_nx;
  logic [GCNT_W-1:0]  good_cnt;
  logic [GCNT_W-1:0]  good_nx;
  logic [GCNT_W-1:0]  good_inc;
  logic               sel_nx;

  extclk_edgedet u_edgedet (
    .clk  (clk),
    .rst  (rst),
    .d    (fast_clk_ext),
    .rise (rise)
  );

  // The value judged on the evaluation cycle already includes an edge seen in
  // that same cycle; the counter then restarts from zero for the next window.
  assign eval     = (win_cnt == WIN_LAST);
  assign eval_cnt = sat_inc(edge_cnt, rise);
  assign win_good = (eval_cnt >= MIN_COUNT) && (eval_cnt <= MAX_COUNT);
  assign good_inc = good_cnt + 1'b1;

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    if (eval) begin
      case (state)
        USE_DIV: begin
          if (win_good) begin
            if (GOOD_WINDOWS <= 1) begin
              state_nx = USE_EXT;
              good_nx  = GOOD_TGT;
            end else begin
              state_nx = QUALIFY;
              good_nx  = GCNT_W'(1);
            end
          end
        end
        QUALIFY: begin
          if (win_good) begin
            good_nx = good_inc;
            if (good_inc >= GOOD_TGT) begin
              state_nx = USE_EXT;
            end
          end else begin
            state_nx = USE_DIV;
            good_nx  = '0;
          end
        end
        USE_EXT: begin
          if (!win_good) begin
            state_nx = USE_DIV;
            good_nx  = '0;
          end
        end
        default: begin
          state_nx = USE_DIV;
          good_nx  = '0;
        end
      endcase
    end
  end

  // Select is registered from the next FSM state so that in auto modes it
  // moves on the very edge that ends the evaluation cycle, while a mode change
  // reaches the output one clock later without touching the FSM.
  always_comb begin
    case (mode_t'(mode))
      MODE_DIV: sel_nx = 1'b0;
      MODE_EXT: sel_nx = 1'b1;
      default:  sel_nx = (state_nx == USE_EXT);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt      <= '0;
      edge_cnt     <= '0;
      last_count   <= '0;
      ext_ok       <= 1'b0;
      window_done  <= 1'b0;
      state        <= USE_DIV;
      good_cnt     <= '0;
      fast_clk_sel <= 1'b0;
    end else begin
      window_done  <= eval;
      state        <= state_nx;
      good_cnt     <= good_nx;
      fast_clk_sel <= sel_nx;
      if (eval) begin
        win_cnt    <= '0;
        edge_cnt   <= '0;
        last_count <= eval_cnt;
        ext_ok     <= win_good;
      end else begin
        win_cnt    <= win_cnt + 1'b1;
        edge_cnt   <= eval_cnt;
      end
    end
  end

endmodule

// File: tb/tb_extclk_monitor.sv
module tb_extclk_monitor;

  localparam int W    = 100;
  localparam int MINE = 10;
  localparam int MAXE = 15;
  localparam int GW   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fast_clk_ext = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        fast_clk_sel;
  logic        ext_ok;
  logic        window_done;
  logic [15:0] last_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  extclk_monitor #(
    .WINDOW_CYCLES (W),
    .MIN_EDGES     (MINE),
    .MAX_EDGES     (MAXE),
    .GOOD_WINDOWS  (GW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fast_clk_ext (fast_clk_ext),
    .mode         (mode),
    .fast_clk_sel (fast_clk_sel),
    .ext_ok       (ext_ok),
    .last_count   (last_count),
    .window_done  (window_done)
  );

  always #5 clk = ~clk;

  // Cycles since the last reset edge.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Reference model: pin samples are counted on the 3rd edge after sampling,
  // windows close every W cycles, and the external clock is selected once the
  // run of consecutive good windows reaches GW.
  logic        h1, h2, h3;
  int          m_cnt;
  int          streak;
  logic        m_sel, m_done, m_ok;
  logic [15:0] m_last;

  always @(posedge clk) begin : model
    int c;
    int s;
    if (rst) begin
      h1 <= 1'b0; h2 <= 1'b0; h3 <= 1'b0;
      m_cnt <= 0; streak <= 0;
      m_sel <= 1'b0; m_done <= 1'b0; m_ok <= 1'b0; m_last <= '0;
    end else begin
      h1 <= fast_clk_ext; h2 <= h1; h3 <= h2;
      c = m_cnt + ((h2 && !h3) ? 1 : 0);
      if (c > 65535) c = 65535;
      s = streak;
      if ((cyc % W) == W - 1) begin
        m_last <= 16'(c);
        m_ok   <= (c >= MINE && c <= MAXE);
        s = (c >= MINE && c <= MAXE) ? streak + 1 : 0;
        m_cnt  <= 0;
        m_done <= 1'b1;
      end else begin
        m_cnt  <= c;
        m_done <= 1'b0;
      end
      streak <= s;
      m_sel  <= (mode == 2'b01) ? 1'b0 : (mode == 2'b10) ? 1'b1 : (s >= GW);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mode = 2'b00; fast_clk_ext = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; fast_clk_ext = 1'b1; mode = 2'b10;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (fast_clk_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b expected 0", fast_clk_sel); end
    n_checks++;
    if (ext_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok got %b expected 0", ext_ok); end
    n_checks++;
    if (last_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", last_count); end
    n_checks++;
    if (window_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", window_done); end
    rst = 1'b0; mode = 2'b00; fast_clk_ext = 1'b0;
  endtask

  // Period-8 external clock in auto mode, then loss of the external clock.
  task automatic test_auto_qualify_and_loss();
    int ph;
    int first_sel;
    ph = int'($urandom_range(0, 7));
    first_sel = 0;
    do_reset();
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      n_checks++;
      if ({fast_clk_sel, window_done, ext_ok, last_count} !== {m_sel, m_done, m_ok, m_last}) begin
        n_fail++;
        $display("FAIL auto_model k=%0d got sel/done/ok/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 k, fast_clk_sel, window_done, ext_ok, last_count, m_sel, m_done, m_ok, m_last);
      end
      if (window_done && k <= 400) begin
        n_checks++;
        if (!(last_count inside {16'd12, 16'd13}) || ext_ok !== 1'b1) begin
          n_fail++;
          $display("FAIL auto_window k=%0d got cnt=%0d ok=%b expected cnt 12..13 ok=1", k, last_count, ext_ok);
        end
      end
      if (fast_clk_sel === 1'b1 && first_sel == 0) first_sel = k;
      if (k == 500) begin
        n_checks++;
        if ({window_done, last_count, ext_ok, fast_clk_sel} !== {1'b1, 16'd0, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL loss_window got done=%b cnt=%0d ok=%b sel=%b expected 1/0/0/0",
                   window_done, last_count, ext_ok, fast_clk_sel);
        end
      end
      fast_clk_ext = (k < 398) ? (((k + ph) % 8) < 4) : 1'b0;
    end
    n_checks++;
    if (first_sel != 300) begin n_fail++; $display("FAIL auto_sel_rise got cycle %0d expected 300", first_sel); end
  endtask

  // Overfrequency windows, then good/good/bad/good pattern.
  task automatic test_overfreq_pattern();
    int ph;
    int wi;
    int per;
    int first_sel;
    ph = int'($urandom_range(0, 7));
    first_sel = 0;
    do_reset();
    for (int k = 1; k <= 900; k++) begin
      @(negedge clk);
      n_checks++;
      if ({fast_clk_sel, window_done, ext_ok, last_count} !== {m_sel, m_done, m_ok, m_last}) begin
        n_fail++;
        $display("FAIL ovf_model k=%0d got sel/done/ok/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 k, fast_clk_sel, window_done, ext_ok, last_count, m_sel, m_done, m_ok, m_last);
      end
      if (window_done && k <= 300) begin
        n_checks++;
        if (ext_ok !== 1'b0 || last_count < 16'd24) begin
          n_fail++;
          $display("FAIL ovf_window k=%0d got ok=%b cnt=%0d expected ok=0 cnt>=24", k, ext_ok, last_count);
        end
      end
      if (fast_clk_sel === 1'b1 && first_sel == 0) first_sel = k;
      wi  = (k + 2) / 100;
      per = (wi < 3 || wi == 5) ? 4 : 8;
      fast_clk_ext = ((k + ph) % per) < (per / 2);
    end
    n_checks++;
    if (first_sel != 900) begin n_fail++; $display("FAIL ovf_sel_rise got cycle %0d expected 900", first_sel); end
  endtask

  task automatic test_mode();
    int ph;
    ph = int'($urandom_range(0, 7));
    do_reset();
    for (int k = 1; k <= 760; k++) begin
      @(negedge clk);
      n_checks++;
      if ({fast_clk_sel, window_done, ext_ok, last_count} !== {m_sel, m_done, m_ok, m_last}) begin
        n_fail++;
        $display("FAIL mode_model k=%0d got sel/done/ok/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 k, fast_clk_sel, window_done, ext_ok, last_count, m_sel, m_done, m_ok, m_last);
      end
      if (k == 50 || k == 651) begin
        n_checks++;
        if (fast_clk_sel !== 1'b0) begin n_fail++; $display("FAIL mode_sel k=%0d got %b expected 0", k, fast_clk_sel); end
      end
      if (k == 51 || k == 721 || k == 760) begin
        n_checks++;
        if (fast_clk_sel !== 1'b1) begin n_fail++; $display("FAIL mode_sel k=%0d got %b expected 1", k, fast_clk_sel); end
      end
      if (k == 100 || k == 200) begin
        n_checks++;
        if ({window_done, ext_ok, fast_clk_sel} !== 3'b101) begin
          n_fail++;
          $display("FAIL mode_forced_window k=%0d got done=%b ok=%b sel=%b expected 1/0/1", k, window_done, ext_ok, fast_clk_sel);
        end
      end
      case (k)
        50:  mode = 2'b10;
        250: mode = 2'b00;
        650: mode = 2'b01;
        720: mode = 2'b00;
        740: mode = 2'b11;
        default: ;
      endcase
      fast_clk_ext = (k >= 298) ? (((k + ph) % 8) < 4) : 1'b0;
    end
    mode = 2'b00;
  endtask

  task automatic test_reset_mid();
    int ph;
    int first_done;
    int first_sel;
    ph = int'($urandom_range(0, 7));
    first_done = 0;
    first_sel = 0;
    do_reset();
    for (int k = 1; k <= 560; k++) begin
      @(negedge clk);
      n_checks++;
      if ({fast_clk_sel, window_done, ext_ok, last_count} !== {m_sel, m_done, m_ok, m_last}) begin
        n_fail++;
        $display("FAIL rstmid_model k=%0d got sel/done/ok/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 k, fast_clk_sel, window_done, ext_ok, last_count, m_sel, m_done, m_ok, m_last);
      end
      if (k == 250) begin
        n_checks++;
        if ({fast_clk_sel, window_done, ext_ok, last_count} !== 19'd0) begin
          n_fail++;
          $display("FAIL rstmid_outputs got sel=%b done=%b ok=%b cnt=%0d expected all 0",
                   fast_clk_sel, window_done, ext_ok, last_count);
        end
      end
      if (k > 250 && window_done === 1'b1 && first_done == 0) first_done = k;
      if (k > 250 && fast_clk_sel === 1'b1 && first_sel == 0) first_sel = k;
      rst = (k == 249);
      fast_clk_ext = ((k + ph) % 8) < 4;
    end
    n_checks++;
    if (first_done != 350) begin n_fail++; $display("FAIL rstmid_first_done got cycle %0d expected 350", first_done); end
    n_checks++;
    if (first_sel != 550) begin n_fail++; $display("FAIL rstmid_sel_rise got cycle %0d expected 550", first_sel); end
  endtask

  // Exact edge counts per window; pin set at negedge k belongs to the window
  // ending at D when D-102 <= k <= D-3.
  task automatic test_boundary();
    bit pat [0:799];
    int exp_n [1:8];
    int d;
    int n;
    int off;
    for (int i = 0; i < 800; i++) pat[i] = 1'b0;
    exp_n[1] = 10; exp_n[2] = 15; exp_n[3] = 9; exp_n[4] = 16;
    for (int w = 1; w <= 4; w++) begin
      d = 100 * w;
      for (int t = 0; t < exp_n[w]; t++) pat[d - 3 - 2 * t] = 1'b1;
    end
    for (int t = 0; t < 9; t++) pat[500 - 4 - 2 * t] = 1'b1;
    pat[500 - 2] = 1'b1;
    exp_n[5] = 9;
    for (int t = 0; t < 9; t++) pat[600 - 3 - 2 * t] = 1'b1;
    exp_n[6] = 10;
    for (int w = 7; w <= 8; w++) begin
      d   = 100 * w;
      n   = int'($urandom_range(5, 20));
      off = int'($urandom_range(0, 99 - 2 * n));
      exp_n[w] = n;
      for (int t = 0; t < n; t++) pat[d - 3 - off - 2 * t] = 1'b1;
    end
    do_reset();
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      n_checks++;
      if ({fast_clk_sel, window_done, ext_ok, last_count} !== {m_sel, m_done, m_ok, m_last}) begin
        n_fail++;
        $display("FAIL bnd_model k=%0d got sel/done/ok/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 k, fast_clk_sel, window_done, ext_ok, last_count, m_sel, m_done, m_ok, m_last);
      end
      if (k % 100 == 0) begin
        n_checks++;
        if (window_done !== 1'b1 || last_count !== 16'(exp_n[k / 100]) ||
            ext_ok !== (exp_n[k / 100] >= MINE && exp_n[k / 100] <= MAXE)) begin
          n_fail++;
          $display("FAIL bnd_window k=%0d got done=%b cnt=%0d ok=%b expected done=1 cnt=%0d",
                   k, window_done, last_count, ext_ok, exp_n[k / 100]);
        end
      end
      fast_clk_ext = (k < 800) ? pat[k] : 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_auto_qualify_and_loss();
    test_overfreq_pattern();
    test_mode();
    test_reset_mid();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/extclk_monitor.md
# extclk_monitor

Qualifies the external 6.5536 MHz reference against the 50 MHz system clock and generates the registered `fast_clk_sel` that drives the fast-clock multiplexer. It sits directly upstream of the mux. It counts synchronised rising edges of `fast_clk_ext` over fixed windows. It switches to the external clock only after several consecutive in-range windows, and falls back to the divided 5 MHz clock on the first bad window.

## Interface
- `WINDOW_CYCLES`, 50000: system cycles per measurement window (1 ms).
- `MIN_EDGES`, 6400: lowest edge count accepted as good.
- `MAX_EDGES`, 6700: highest edge count accepted as good.
- `GOOD_WINDOWS`, 4: consecutive good windows required before selecting external.
- `clk` input 1: 50 MHz system clock. One clock; reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `fast_clk_ext` input 1: external clock. Asynchronous to `clk`; used only as sampled data.
- `mode` input 2: 00 auto, 01 force divided, 10 force external, 11 auto.
- `fast_clk_sel` output 1: 1 selects external, 0 selects divided. Registered.
- `ext_ok` output 1: last completed window was in range.
- `last_count` output 16: edge count of last completed window.
- `window_done` output 1: one-cycle pulse when `last_count`/`ext_ok` update.

## Operation
- Input path:
  - 2-FF synchroniser on `fast_clk_ext`, then a previous-value register.
  - A rising edge is detected when the synchronised value is 1 and the previous value was 0.
- Window counter, 16 bit:
  - Counts 0..WINDOW_CYCLES-1 and wraps.
  - The cycle with count = WINDOW_CYCLES-1 is the evaluation cycle.
- Edge counter, 16 bit:
  - Saturates at 16'hFFFF and never wraps.
  - On the evaluation cycle, the value evaluated includes any edge detected in that same cycle.
  - The counter restarts at 0, or at 1 if an edge is detected in the cycle after evaluation.
- Good window: MIN_EDGES ≤ count ≤ MAX_EDGES, both bounds inclusive.
- FSM states, evaluated only at window boundaries:
  - USE_DIV: good window → QUALIFY with good_cnt=1. Bad window → stay.
  - QUALIFY: good window → good_cnt+1; when it reaches GOOD_WINDOWS → USE_EXT. Bad window → USE_DIV, good_cnt=0.
  - USE_EXT: bad window → USE_DIV, good_cnt=0. Good window → stay.
  - GOOD_WINDOWS=1 goes USE_DIV→USE_EXT directly on the first good window.
- `fast_clk_sel` source:
  - Auto modes: 1 iff state is USE_EXT.
  - Modes 01 and 10: the forced value.
  - The FSM and measurement keep running in every mode.
- Mode changes: take effect on `fast_clk_sel` one clock after `mode` changes. The FSM state is unaffected.
- Stuck or absent external clock: count 0 → bad window.
- Overfrequency or glitching: count above MAX_EDGES → bad window.

## Timing
- Reset values:
  - `fast_clk_sel`=0, `ext_ok`=0, `last_count`=0, `window_done`=0.
  - FSM in USE_DIV; good_cnt, window counter and edge counter all 0.
  - Synchroniser flops reset to 0.
- Edge latency: a pin rising edge is counted on the 3rd `clk` edge after sampling.
- Window result latency:
  - `last_count`, `ext_ok`, the FSM state and `window_done` update on the clock edge ending the evaluation cycle.
  - In auto mode, `fast_clk_sel` changes on that same edge.
- `fast_clk_sel` changes only at window boundaries (auto) or one cycle after a `mode` change. It never toggles within a window.
- Reset mid-window: all counts are discarded, `fast_clk_sel` returns to 0 on the next edge, and the first window restarts from 0.
- The first window after reset needs exactly WINDOW_CYCLES cycles.

## Structure
- Package `fastclk_pkg` holds:
  - `state_t` enum {USE_DIV, QUALIFY, USE_EXT}.
  - `mode_t` enum {MODE_AUTO, MODE_DIV, MODE_EXT, MODE_AUTO2}.
  - The 16-bit count width constant.
- One sub-module, `extclk_edgedet`: synchroniser plus rising-edge pulse generator. Ports `clk`, `rst`, `d`, `rise`.

## Test plan
All scenarios use WINDOW_CYCLES=100, MIN_EDGES=10, MAX_EDGES=15, GOOD_WINDOWS=3, with the external clock at a period of 8 `clk` cycles, giving 12 or 13 edges per window.
- Reset, then ext running in auto mode:
  - `last_count` ∈ {12,13}, `ext_ok`=1 at each `window_done`.
  - `fast_clk_sel` rises on the edge ending the 3rd window (cycle 300) and not earlier.
- With sel=1, hold ext low:
  - Next window gives `last_count`=0 and `ext_ok`=0.
  - `fast_clk_sel`=0 on that window's end edge.
- Ext period 4 cycles (25 edges): `ext_ok`=0 every window and `fast_clk_sel` stays 0. Good, good, bad, good sequence: sel stays 0, and good_cnt restarts after the bad window.
- `mode`=10 with ext absent: `fast_clk_sel`=1 one cycle after the mode change, while `ext_ok`=0 keeps updating. `mode`=01 while in USE_EXT: sel=0 next cycle. Returning to 00 restores sel=1.
- Assert `rst` at cycle 250 while in QUALIFY: all outputs return to reset values, and the next `window_done` arrives at cycle 350.
- Boundary counts:
  - Exactly 10 and 15 edges → good; 9 and 16 → bad.
  - Edge on the evaluation cycle is included in the current window.
  - Edge on the following cycle is counted in the next window.
